// File: rtl/inv_subbytes_seq_if.sv
// rtl/inv_subbytes_seq_if.sv - state-in / result-out handshake bundle for inv_subbytes_seq
interface inv_subbytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_subbytes_seq.sv
// rtl/inv_subbytes_seq.sv - iterative AES InvSubBytes, LANES inverse S-box lookups per cycle
module inv_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_subbytes_seq_if.slave  bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    st_q;
  logic [127:0]    st_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  // Byte 0 lives in the top of the word, so lane positions count down from bit 127.
  always_comb begin
    int idx;
    idx  = 0;
    st_d = st_q;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(cnt_q) * LANES + l;
      st_d[127 - 8*idx -: 8] = INV_SBOX[st_q[127 - 8*idx -: 8]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            st_q       <= bus.in_data;
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          st_q <= st_d;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = st_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb/tb_inv_subbytes_seq.sv - directed and randomized checks of inv_subbytes_seq at LANES 4, 1 and 16
module tb_inv_subbytes_seq;

  logic clk;
  logic rst_n;

  inv_subbytes_seq_if u_if4 ();
  inv_subbytes_seq_if u_if1 ();
  inv_subbytes_seq_if u_if16 ();

  inv_subbytes_seq #(.LANES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(u_if4.slave));
  inv_subbytes_seq #(.LANES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));
  inv_subbytes_seq #(.LANES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(u_if16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic ir(input int s);
    case (s) 0: return u_if4.in_ready; 1: return u_if1.in_ready; default: return u_if16.in_ready; endcase
  endfunction
  function automatic logic ov(input int s);
    case (s) 0: return u_if4.out_valid; 1: return u_if1.out_valid; default: return u_if16.out_valid; endcase
  endfunction
  function automatic logic bz(input int s);
    case (s) 0: return u_if4.busy; 1: return u_if1.busy; default: return u_if16.busy; endcase
  endfunction
  function automatic logic [127:0] od(input int s);
    case (s) 0: return u_if4.out_data; 1: return u_if1.out_data; default: return u_if16.out_data; endcase
  endfunction

  task automatic set_v(input int s, input logic b);
    case (s) 0: u_if4.in_valid = b; 1: u_if1.in_valid = b; default: u_if16.in_valid = b; endcase
  endtask
  task automatic set_r(input int s, input logic b);
    case (s) 0: u_if4.out_ready = b; 1: u_if1.out_ready = b; default: u_if16.out_ready = b; endcase
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_idle(input int s, input string tag);
    chk({tag, "_in_ready"}, 128'(ir(s)), 128'd1);
    chk({tag, "_out_valid"}, 128'(ov(s)), 128'd0);
    chk({tag, "_busy"}, 128'(bz(s)), 128'd0);
    chk({tag, "_out_data"}, od(s), 128'd0);
  endtask

  // One block: accept d, measure latency, check result, optional stall with ignored in_valid pulses.
  task automatic run_block(input int s, input logic [127:0] d, input logic [127:0] e,
                           input int lat_exp, input int stall, input bit early, input string tag);
    int lat;
    logic [127:0] snap;
    @(negedge clk);
    chk({tag, "_ready_before"}, 128'(ir(s)), 128'd1);
    u_if4.in_data = d; u_if1.in_data = d; u_if16.in_data = d;
    set_v(s, 1'b1);
    @(negedge clk);
    set_v(s, 1'b0);
    chk({tag, "_busy_after_accept"}, 128'(bz(s)), 128'd1);
    if (early) set_r(s, 1'b1);
    lat = 0;
    while (!ov(s) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    chk({tag, "_data"}, od(s), e);
    if (!early) begin
      snap = od(s);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        set_v(s, 1'($urandom % 2));
      end
      if (stall > 0) begin
        chk({tag, "_stall_stable"}, od(s), snap);
        chk({tag, "_stall_in_ready"}, 128'(ir(s)), 128'd0);
        chk({tag, "_stall_out_valid"}, 128'(ov(s)), 128'd1);
      end
      set_v(s, 1'b0);
      set_r(s, 1'b1);
    end
    @(negedge clk);
    set_r(s, 1'b0);
    chk({tag, "_out_valid_drop"}, 128'(ov(s)), 128'd0);
    chk({tag, "_ready_return"}, 128'(ir(s)), 128'd1);
    chk({tag, "_busy_drop"}, 128'(bz(s)), 128'd0);
  endtask

  initial begin
    logic [127:0] orig;
    build_sbox();
    for (int s = 0; s < 3; s++) begin
      set_v(s, 1'b0);
      set_r(s, 1'b0);
    end
    u_if4.in_data = '0; u_if1.in_data = '0; u_if16.in_data = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s, "reset");

    run_block(0, {16{8'h63}}, 128'd0, 4, 0, 1'b0, "vec63");
    run_block(0, 128'd0, {16{8'h52}}, 4, 0, 1'b1, "vec00_early_ready");
    run_block(0, 128'h637C777B_F26B6FC5_3001672B_FED7AB76,
              128'h00010203_04050607_08090A0B_0C0D0E0F, 4, 0, 1'b0, "mixed_l4");
    run_block(1, 128'h637C777B_F26B6FC5_3001672B_FED7AB76,
              128'h00010203_04050607_08090A0B_0C0D0E0F, 16, 0, 1'b0, "mixed_l1");
    run_block(2, 128'h637C777B_F26B6FC5_3001672B_FED7AB76,
              128'h00010203_04050607_08090A0B_0C0D0E0F, 1, 0, 1'b0, "mixed_l16");
    run_block(0, {16{8'h7c}}, {16{8'h01}}, 4, 10, 1'b0, "backpressure");

    @(negedge clk);
    u_if4.in_data = {16{8'h63}};
    set_v(0, 1'b1);
    @(negedge clk);
    set_v(0, 1'b0);
    @(negedge clk);
    chk("midrst_no_valid", 128'(ov(0)), 128'd0);
    rst_n = 1'b0;
    #1;
    check_idle(0, "midrst_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_never_valid", 128'(ov(0)), 128'd0);
    end
    run_block(0, 128'h637C777B_F26B6FC5_3001672B_FED7AB76,
              128'h00010203_04050607_08090A0B_0C0D0E0F, 4, 0, 1'b0, "after_midrst");

    for (int n = 0; n < 1000; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      run_block(0, fwd_state(orig), orig, 4, int'($urandom_range(0, 3)),
                1'($urandom % 4 == 0), "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
